// File: rtl/temperature_pkg.sv
// Purpose: shared constants and FSM state type for the sensor acquisition block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package temperature_pkg;

    localparam int NUM_SENSORS  = 5;
    localparam int TEMP_W       = 8;
    localparam int SENSOR_IDX_W = 3;
    localparam int CNT_W        = 8;
    localparam logic [TEMP_W-1:0] TEMP_MAX = 8'd125;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        NEXT,
        PUBLISH
    } acq_state_t;

endpackage

// File: rtl/acq_timeout_counter.sv
// Purpose: per-sensor response timeout; loadable down-counter with an expiry flag.
// Latency: load takes effect next cycle; zero is combinational from the count.
// Backpressure: none; decrements whenever dec is high and the count is nonzero.
module acq_timeout_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Reload on request, otherwise count down and stick at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // High when the decrement in this cycle lands on zero (count is 1 or 0),
    // so a WAIT lasting exactly load_val cycles ends on this flag.
    assign zero = (cnt[CNT_W-1:1] == '0);

endmodule

// File: rtl/sensor_acquisition.sv
// Purpose: polls 5 temperature sensors over a shared req/ack bus and publishes a full frame atomically.
// Latency: 17 cycles start-to-frame_valid when every sensor acks one cycle after req; 5*(TIMEOUT+2)+2 if all time out.
// Backpressure: none downstream; start_i ignored while busy; SENSOR_RANGE_CHECK_EN adds range_err_o and rejects readings > 125.
module sensor_acquisition
    import temperature_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    output logic                          req_o,
    output logic [SENSOR_IDX_W-1:0]       sel_o,
    input  logic                          ack_i,
    input  logic [TEMP_W-1:0]             data_i,
    output logic [NUM_SENSORS*TEMP_W-1:0] sensors_data_o,
    output logic [NUM_SENSORS-1:0]        sensors_en_o,
    output logic                          frame_valid_o,
    output logic                          busy_o
`ifdef SENSOR_RANGE_CHECK_EN
    ,
    output logic                          range_err_o
`endif
);

    localparam logic [CNT_W-1:0]        TIMEOUT_LD = CNT_W'(TIMEOUT);
    localparam logic [SENSOR_IDX_W-1:0] LAST_IDX   = SENSOR_IDX_W'(NUM_SENSORS - 1);

    acq_state_t                    state;
    logic [SENSOR_IDX_W-1:0]       idx;
    logic [NUM_SENSORS*TEMP_W-1:0] shadow_data;
    logic [NUM_SENSORS-1:0]        shadow_en;
    logic                          tmo_zero;
    logic                          in_range;

    acq_timeout_counter #(
        .CNT_W(CNT_W)
    ) u_timeout (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (state == REQ),
        .load_val (TIMEOUT_LD),
        .dec      (state == WAIT),
        .zero     (tmo_zero)
    );

`ifdef SENSOR_RANGE_CHECK_EN
    // Readings above the plausible maximum indicate a faulty sensor.
    assign in_range = (data_i <= TEMP_MAX);
`else
    assign in_range = 1'b1;
`endif

    // Scan sequencer; req_o/sel_o are registered and raised on entry to REQ
    // so the selected sensor sees the request during the REQ cycle itself.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            idx            <= '0;
            req_o          <= 1'b0;
            sel_o          <= '0;
            shadow_data    <= '0;
            shadow_en      <= '0;
            sensors_data_o <= '0;
            sensors_en_o   <= '0;
            frame_valid_o  <= 1'b0;
            busy_o         <= 1'b0;
`ifdef SENSOR_RANGE_CHECK_EN
            range_err_o    <= 1'b0;
`endif
        end else begin
            frame_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        shadow_en <= '0;
                        idx       <= '0;
                        sel_o     <= '0;
                        req_o     <= 1'b1;
                        busy_o    <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // An ack on the expiry cycle still wins over the timeout.
                    if (ack_i) begin
                        shadow_data[idx*TEMP_W +: TEMP_W] <= in_range ? data_i : '0;
                        shadow_en[idx]                    <= in_range;
`ifdef SENSOR_RANGE_CHECK_EN
                        if (!in_range) begin
                            range_err_o <= 1'b1;
                        end
`endif
                        req_o <= 1'b0;
                        state <= NEXT;
                    end else if (tmo_zero) begin
                        shadow_data[idx*TEMP_W +: TEMP_W] <= '0;
                        shadow_en[idx]                    <= 1'b0;
                        req_o                             <= 1'b0;
                        state                             <= NEXT;
                    end
                end
                NEXT: begin
                    if (idx == LAST_IDX) begin
                        state <= PUBLISH;
                    end else begin
                        idx   <= idx + 1'b1;
                        sel_o <= idx + 1'b1;
                        req_o <= 1'b1;
                        state <= REQ;
                    end
                end
                PUBLISH: begin
                    sensors_data_o <= shadow_data;
                    sensors_en_o   <= shadow_en;
                    frame_valid_o  <= 1'b1;
                    busy_o         <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    req_o  <= 1'b0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_acquisition.sv
// Purpose: scoreboard bench for sensor_acquisition with a behavioural sensor bus model.
// Latency: expected frame cycle derived from per-sensor ack delays.
// Backpressure: n/a.
module tb_sensor_acquisition;

`ifdef SENSOR_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif
    localparam int TMO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        req_o;
    logic [2:0]  sel_o;
    logic        ack_i;
    logic [7:0]  data_i;
    logic [39:0] sensors_data_o;
    logic [4:0]  sensors_en_o;
    logic        frame_valid_o;
    logic        busy_o;
`ifdef SENSOR_RANGE_CHECK_EN
    logic        range_err_o;
`endif

    always #5 clk_i = ~clk_i;

    sensor_acquisition #(.TIMEOUT(TMO)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .req_o          (req_o),
        .sel_o          (sel_o),
        .ack_i          (ack_i),
        .data_i         (data_i),
        .sensors_data_o (sensors_data_o),
        .sensors_en_o   (sensors_en_o),
        .frame_valid_o  (frame_valid_o),
        .busy_o         (busy_o)
`ifdef SENSOR_RANGE_CHECK_EN
        ,
        .range_err_o    (range_err_o)
`endif
    );

    typedef struct {
        logic [39:0] data;
        logic [4:0]  en;
        int          due;
        logic        rerr;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic [7:0] rdata [5];
    int         delay [5];
    logic       spur_ack = 1'b0;
    logic       rerr_model = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sensor bus model: acks delay[k] cycles after req rises (0 = never acks).
    initial begin : sensor_model
        logic   req_prev;
        int     wcnt;
        int     cur;
        req_prev = 1'b0;
        wcnt     = 0;
        cur      = 0;
        ack_i    = 1'b0;
        data_i   = 8'h00;
        forever begin
            @(posedge clk_i);
            #1;
            ack_i = 1'b0;
            if (rst_i || !req_o) begin
                req_prev = 1'b0;
                wcnt     = 0;
            end else if (!req_prev) begin
                req_prev = 1'b1;
                cur      = int'(sel_o);
                wcnt     = 0;
            end else begin
                wcnt++;
                if (cur < 5 && delay[cur] != 0 && wcnt == delay[cur]) begin
                    ack_i  = 1'b1;
                    data_i = rdata[cur];
                end
            end
            if (spur_ack) begin
                ack_i  = 1'b1;
                data_i = 8'hEE;
            end
        end
    end

    // Monitor: every frame_valid pulse must match the oldest expected frame.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (frame_valid_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got frame_valid at cycle %0d, expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    check("frame_data", 64'(sensors_data_o), 64'(e.data));
                    check("frame_en", 64'(sensors_en_o), 64'(e.en));
                    check("frame_cycle", 64'(cyc), 64'(e.due));
`ifdef SENSOR_RANGE_CHECK_EN
                    check("frame_range_err", 64'(range_err_o), 64'(e.rerr));
`endif
                end
            end
        end
    end

    // Push the expected frame for the current sensor table, then pulse start.
    task automatic do_scan();
        exp_t e;
        int   lat;
        lat    = 2;
        e.data = '0;
        e.en   = '0;
        for (int k = 0; k < 5; k++) begin
            if (delay[k] >= 1 && delay[k] <= TMO) begin
                lat += 2 + delay[k];
                if (RANGE_EN && rdata[k] > 8'd125) begin
                    rerr_model = 1'b1;
                end else begin
                    e.data[k*8 +: 8] = rdata[k];
                    e.en[k]          = 1'b1;
                end
            end else begin
                lat += 2 + TMO;
            end
        end
        e.due  = cyc + lat;
        e.rerr = rerr_model;
        sb.push_back(e);
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy_o) && n < 2000) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no frame within %0d cycles, expected one", name, n);
            sb.delete();
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_table(input logic [39:0] vals, input int d0, input int d1,
                             input int d2, input int d3, input int d4);
        for (int k = 0; k < 5; k++) rdata[k] = vals[k*8 +: 8];
        delay[0] = d0; delay[1] = d1; delay[2] = d2; delay[3] = d3; delay[4] = d4;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        set_table(40'h1C1A181614, 1, 1, 1, 1, 1);
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_req", 64'(req_o), 64'd0);
        check("rst_sel", 64'(sel_o), 64'd0);
        check("rst_data", 64'(sensors_data_o), 64'd0);
        check("rst_en", 64'(sensors_en_o), 64'd0);
        check("rst_fv", 64'(frame_valid_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
`ifdef SENSOR_RANGE_CHECK_EN
        check("rst_range_err", 64'(range_err_o), 64'd0);
`endif
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;

        // All sensors ack one cycle after req: 17-cycle frame.
        set_table(40'h1C1A181614, 1, 1, 1, 1, 1);
        do_scan();
        check("scan_busy", 64'(busy_o), 64'd1);
        wait_done("scan_a");
        check("a_data", 64'(sensors_data_o), 64'h1C1A181614);
        check("a_en", 64'(sensors_en_o), 64'h1F);

        // Sensor 2 silent: times out, 15 extra cycles.
        set_table(40'h1C1A181614, 1, 1, 0, 1, 1);
        do_scan();
        wait_done("scan_b");
        check("b_data", 64'(sensors_data_o), 64'h1C1A001614);
        check("b_en", 64'(sensors_en_o), 64'h1B);

        // Sensor 0 acks on the expiry cycle: ack wins.
        set_table(40'h1C1A181630, TMO, 1, 1, 1, 1);
        do_scan();
        wait_done("scan_c");
        check("c_data", 64'(sensors_data_o), 64'h1C1A181630);
        check("c_en", 64'(sensors_en_o), 64'h1F);

        // Spurious ack in IDLE must change nothing.
        @(negedge clk_i);
        spur_ack = 1'b1;
        @(negedge clk_i);
        spur_ack = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("spur_busy", 64'(busy_o), 64'd0);
        check("spur_req", 64'(req_o), 64'd0);
        check("spur_data", 64'(sensors_data_o), 64'h1C1A181630);

        // Out-of-range reading on sensor 4, plus a start pulse mid-scan (ignored).
        set_table(40'hC8281E140A, 1, 1, 1, 1, 1);
        do_scan();
        repeat (4) @(posedge clk_i);
        #1;
        check("midscan_busy", 64'(busy_o), 64'd1);
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        wait_done("scan_d");
        check("d_data", 64'(sensors_data_o), RANGE_EN ? 64'h00281E140A : 64'hC8281E140A);
        check("d_en", 64'(sensors_en_o), RANGE_EN ? 64'h0F : 64'h1F);

        // Good scan afterwards: sticky error stays set.
        set_table(40'h1C1A181614, 1, 1, 1, 1, 1);
        do_scan();
        wait_done("scan_e");

        // Reset during WAIT of sensor 3: outputs clear at once, no frame.
        set_table(40'h1C1A181614, 1, 1, 1, 0, 1);
        do_scan();
        n = 0;
        while (!(req_o && sel_o == 3'd3) && n < 200) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check("reach_sensor3", 64'(n < 200), 64'd1);
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        check("mid_rst_data", 64'(sensors_data_o), 64'd0);
        check("mid_rst_en", 64'(sensors_en_o), 64'd0);
        check("mid_rst_req", 64'(req_o), 64'd0);
        check("mid_rst_busy", 64'(busy_o), 64'd0);
`ifdef SENSOR_RANGE_CHECK_EN
        check("mid_rst_range_err", 64'(range_err_o), 64'd0);
`endif
        sb.delete();
        rerr_model = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (30) @(posedge clk_i);
        #1;

        // Clean scan after reset, with readings on the 125/126 boundary.
        set_table(40'h5001007E7D, 1, 1, 1, 1, 1);
        do_scan();
        wait_done("scan_f");
        check("f_data", 64'(sensors_data_o), RANGE_EN ? 64'h500100007D : 64'h5001007E7D);
        check("f_en", 64'(sensors_en_o), RANGE_EN ? 64'h1D : 64'h1F);

        repeat (3) @(posedge clk_i);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sensor_acquisition.md
Name: sensor_acquisition

Overview:
- Producer side of the averaging datapath's sensor interface.
- Polls 5 temperature sensors sequentially over a shared request/acknowledge bus.
- Captures one 8-bit reading per sensor and marks sensors that miss a timeout as disabled.
- Publishes a stable 40-bit data word plus 5-bit enable mask, updated atomically once per completed scan, for the averaging/display path.

Parameters:
- NUM_SENSORS, 5, number of sensors polled per scan (fixed to 5 for the downstream interface).
- TEMP_W, 8, width of one temperature reading.
- TIMEOUT, 16, cycles to wait for ack_i after req_o before declaring a sensor absent (range 1..255).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  scan request; sampled only in IDLE.
- req_o  output  1  read request to the sensor selected by sel_o; level, held until ack or timeout.
- sel_o  output  3  index of the sensor being polled (0..4).
- ack_i  input  1  selected sensor has data_i valid; one-cycle pulse.
- data_i  input  8  reading from the selected sensor, valid with ack_i.
- sensors_data_o  output  40  published readings; sensor k at bits [8k+7:8k].
- sensors_en_o  output  5  published enable mask; bit k = sensor k responded in the last scan.
- frame_valid_o  output  1  one-cycle pulse when the outputs update.
- busy_o  output  1  high while not in IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE; req_o=0; sel_o=0; sensors_data_o=0; sensors_en_o=0; frame_valid_o=0; busy_o=0. Shadow buffers and timeout counter are cleared.
- FSM states: IDLE, REQ, WAIT, NEXT, PUBLISH.
- IDLE: when start_i=1, clear the shadow enable mask, set idx=0, go to REQ.
- REQ: assert req_o, sel_o=idx, load the timeout counter with TIMEOUT, go to WAIT.
- WAIT: req_o stays high.
  - ack_i=1: shadow_data[idx]=data_i, shadow_en[idx]=1, deassert req_o next cycle, go to NEXT.
  - Else the counter decrements. On reaching 0: shadow_data[idx]=0, shadow_en[idx]=0, deassert req_o, go to NEXT.
  - ack_i in the same cycle the counter reaches 0: ack wins and the sample is captured.
- NEXT: if idx==4, go to PUBLISH; else idx=idx+1 and go to REQ.
  - req_o is low for at least one cycle between sensors.
- PUBLISH: copy the shadow buffers to sensors_data_o/sensors_en_o in one cycle, pulse frame_valid_o, go to IDLE.
- Outputs change only in PUBLISH, so downstream logic never sees a partial frame.
- ack_i outside WAIT is ignored. start_i outside IDLE is ignored (no queuing).
- start_i held high in IDLE produces back-to-back scans.
- Latency from start_i to frame_valid_o:
  - All sensors respond with ack one cycle after req_o: 5×(REQ+WAIT+NEXT) = 15 cycles, +1 for PUBLISH, +1 for IDLE sampling = 17 cycles.
  - Worst case (all time out): 5×(TIMEOUT+2)+2 cycles.
- Reset mid-scan: abandon the scan; published outputs return to 0; no frame_valid_o pulse.
- Timeout counter is 8 bits wide; it never wraps because it is reloaded in REQ.

Optional Feature:
- SENSOR_RANGE_CHECK_EN defined: a reading acked with data_i > 8'd125 is treated as a faulty sensor.
  - shadow_en[idx]=0, shadow_data[idx]=0.
  - Sticky output range_err_o (1 bit, reset 0) is set and cleared only by rst_i.
- Not defined: every acked reading is accepted unconditionally; range_err_o does not exist.

Decomposition:
- Package temperature_pkg:
  - NUM_SENSORS=5, TEMP_W=8, SENSOR_IDX_W=3, TEMP_MAX=8'd125.
  - acq_state_t enum {IDLE, REQ, WAIT, NEXT, PUBLISH}.
- One sub-module, acq_timeout_counter: load, decrement, and zero flag.
- The FSM and the shadow/publish registers stay in sensor_acquisition.

Test Plan:
- Reset then start_i pulse; sensors ack one cycle after req_o with data 20,22,24,26,28 → frame_valid_o at cycle 17; sensors_data_o=0x1C1A181614; sensors_en_o=5'b11111.
- Sensor 2 never acks, TIMEOUT=16 → sensors_en_o=5'b11011; bits [23:16]=0; frame_valid_o at 17+15 cycles.
- ack_i exactly on the timeout expiry cycle for sensor 0 with data 0x30 → captured; en bit 0=1.
- Assert rst_i during WAIT of sensor 3 → all outputs 0 immediately; no frame_valid_o; the next start_i gives a clean full scan.
- Spurious ack_i in IDLE and start_i during a scan → no state or output change; exactly one frame_valid_o per accepted start.
- With SENSOR_RANGE_CHECK_EN, sensor 4 returns 200 → sensors_en_o[4]=0; range_err_o=1 and stays set across later good scans.
